pcs_phy_ctrl: RTL



---
 rtl/pcs_ctrl_pkg.sv | 27 ++
 rtl/pcs_ctrl_timer.sv | 39 +++
 rtl/pcs_phy_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pcs_ctrl_pkg.sv
// Shared types and encodings for the PCS power-state / receiver-detect sequencer.
package pcs_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST_WAIT = 3'd0,
    ST_P1       = 3'd1,
    ST_DETECT   = 3'd2,
    ST_P0       = 3'd3,
    ST_LOOPBACK = 3'd4,
    ST_P0S      = 3'd5,
    ST_P0S_EXIT = 3'd6
  } state_e;

  localparam logic [1:0] PD_P0  = 2'b00;
  localparam logic [1:0] PD_P0S = 2'b01;
  localparam logic [1:0] PD_P1  = 2'b10;
  localparam logic [1:0] PD_P2  = 2'b11;

  localparam logic [2:0] RXST_OK  = 3'b000;
  localparam logic [2:0] RXST_DET = 3'b011;

  // States whose entry is reported to the MAC with a PhyStatus pulse.
  function automatic logic is_power_state(input state_e s);
    return (s == ST_P0) || (s == ST_P0S) || (s == ST_P1);
  endfunction

endpackage

// File: rtl/pcs_ctrl_timer.sv
// Loadable down-counter shared by lock, detect and P0s-exit timing.
module pcs_ctrl_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero,
  output logic             last
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);
  assign last = (count_q == CNT_W'(1));

endmodule

// File: rtl/pcs_phy_ctrl.sv
// PIPE power-state and receiver-detect sequencer for one PCS/PMA lane (PCLK domain).
module pcs_phy_ctrl
  import pcs_ctrl_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES     = 64,
  parameter int unsigned DETECT_CYCLES   = 16,
  parameter int unsigned P0S_EXIT_CYCLES = 8,
  parameter int unsigned CNT_W           = 8
) (
  input  logic       PCLK,
  input  logic       RST_n,
  input  logic [1:0] PowerDown,
  input  logic       TxDetectRx_Loopback,
  input  logic       TxElecIdle,
  input  logic       PLL_Locked,
  input  logic       Rx_Present,
  output logic       PhyStatus,
  output logic [2:0] RxStatus,
  output logic       Tx_Idle_PMA,
  output logic       Detect_En,
  output logic       Rx_En,
  output logic       Loopback_En
);

  state_e           state_q, state_d;
  logic             tmr_clear, tmr_load, tmr_zero, tmr_last;
  logic [CNT_W-1:0] tmr_val;

  logic       phy_status_q, phy_status_d;
  logic [2:0] rx_status_q, rx_status_d;
  logic       tx_idle_q, tx_idle_d;
  logic       detect_en_q, detect_en_d;
  logic       rx_en_q, rx_en_d;
  logic       loopback_en_q, loopback_en_d;

  pcs_ctrl_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (PCLK),
    .rst_n    (RST_n),
    .clear    (tmr_clear),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero),
    .last     (tmr_last)
  );

  always_comb begin
    state_d     = state_q;
    tmr_clear   = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    rx_status_d = RXST_OK;
    if (!PLL_Locked) begin
      state_d   = ST_RST_WAIT;
      tmr_clear = 1'b0 | 1'b1;
    end else begin
      case (state_q)
        // Zero means no locked cycle seen yet: the first one arms the count,
        // the timer's last value marks the final required locked cycle.
        ST_RST_WAIT: begin
          if (tmr_zero) begin
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(LOCK_CYCLES - 1);
          end else if (tmr_last) begin
            state_d   = (PowerDown == PD_P0) ? ST_P0 : ST_P1;
            tmr_clear = 1'b1;
          end
        end
        ST_P1: begin
          if (TxDetectRx_Loopback && TxElecIdle) begin
            state_d  = ST_DETECT;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(DETECT_CYCLES);
          end else if (PowerDown == PD_P0) begin
            state_d = ST_P0;
          end else if (PowerDown == PD_P0S) begin
            state_d = ST_P0S;
          end
        end
        ST_DETECT: begin
          if (tmr_last) begin
            state_d     = ST_P1;
            rx_status_d = Rx_Present ? RXST_DET : RXST_OK;
          end
        end
        ST_P0: begin
          if (TxDetectRx_Loopback && !TxElecIdle) begin
            state_d = ST_LOOPBACK;
          end else if (PowerDown == PD_P0S) begin
            state_d = ST_P0S;
          end else if (PowerDown[1]) begin
            state_d = ST_P1;
          end
        end
        ST_LOOPBACK: begin
          if (!TxDetectRx_Loopback) begin
            state_d = ST_P0;
          end
        end
        ST_P0S: begin
          if (PowerDown == PD_P0) begin
            state_d  = ST_P0S_EXIT;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(P0S_EXIT_CYCLES);
          end else if (PowerDown[1]) begin
            state_d = ST_P1;
          end
        end
        ST_P0S_EXIT: begin
          if (tmr_last) begin
            state_d = ST_P0;
          end
        end
        default: state_d = ST_RST_WAIT;
      endcase
    end
  end

  // Outputs decode the next state so they change together with state_q.
  always_comb begin
    phy_status_d  = (state_d == ST_RST_WAIT) ||
                    ((state_d != state_q) && is_power_state(state_d) &&
                     (state_q != ST_RST_WAIT) && (state_q != ST_LOOPBACK));
    detect_en_d   = (state_d == ST_DETECT);
    loopback_en_d = (state_d == ST_LOOPBACK);
    rx_en_d       = (state_d == ST_P0) || (state_d == ST_LOOPBACK) ||
                    (state_d == ST_P0S) || (state_d == ST_P0S_EXIT);
    case (state_d)
      ST_P0:       tx_idle_d = TxElecIdle;
      ST_LOOPBACK: tx_idle_d = 1'b0;
      default:     tx_idle_d = 1'b1;
    endcase
  end

  always_ff @(posedge PCLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q       <= ST_RST_WAIT;
      phy_status_q  <= 1'b1;
      rx_status_q   <= RXST_OK;
      tx_idle_q     <= 1'b1;
      detect_en_q   <= 1'b0;
      rx_en_q       <= 1'b0;
      loopback_en_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      phy_status_q  <= phy_status_d;
      rx_status_q   <= rx_status_d;
      tx_idle_q     <= tx_idle_d;
      detect_en_q   <= detect_en_d;
      rx_en_q       <= rx_en_d;
      loopback_en_q <= loopback_en_d;
    end
  end

  assign PhyStatus   = phy_status_q;
  assign RxStatus    = rx_status_q;
  assign Tx_Idle_PMA = tx_idle_q;
  assign Detect_En   = detect_en_q;
  assign Rx_En       = rx_en_q;
  assign Loopback_En = loopback_en_q;

endmodule
